// File: rtl/stream_demux_pkg.sv
// Shared constants for the registered 1:N stream demultiplexer.
// Holds the mode encodings, the slot state type and the select-width helper.
package stream_demux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // A single-bit select is still needed for two channels.
  function automatic int calc_sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register slice for a single demux channel.
// The lane reads zero whenever it holds no word.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // state      | meaning
  // SLOT_EMPTY | no word held, lane data is zero
  // SLOT_FULL  | word held and presented on the lane
  slot_state_e state;
  slot_state_e state_nxt;
  logic        pop;

  assign pop = valid && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SLOT_EMPTY: if (load) state_nxt = SLOT_FULL;
      SLOT_FULL:  if (pop && !load) state_nxt = SLOT_EMPTY;
      default:    state_nxt = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    valid = (state == SLOT_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (pop) begin
      data <= '0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1:N valid/ready demultiplexer with select and round-robin routing.
// Words routed to a channel index beyond N_OUT are dropped and counted.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int N_OUT = 4,
  parameter int SEL_W = calc_sel_w(N_OUT),
  parameter int ERR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   mode,
  output logic [N_OUT*WIDTH-1:0] out,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [SEL_W-1:0]       rr_ptr,
  output logic [ERR_W-1:0]       err_cnt
);

  logic [SEL_W-1:0] dst;
  logic             in_range;
  logic             dst_valid;
  logic             dst_ready;
  logic             accept;
  logic [N_OUT-1:0] load;

  always_comb begin
    dst       = (mode == MODE_RR) ? rr_ptr : sel;
    in_range  = (int'(dst) < N_OUT);
    dst_valid = 1'b0;
    dst_ready = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (dst == SEL_W'(k)) begin
        dst_valid = out_valid[k];
        dst_ready = out_ready[k];
      end
    end
    // A draining slot accepts in the same cycle, giving full throughput.
    in_ready = in_range ? (!dst_valid || dst_ready) : 1'b1;
    accept   = in_valid && in_ready;
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    assign load[k] = accept && in_range && (dst == SEL_W'(k));

    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[k]),
      .load_data (in),
      .ready     (out_ready[k]),
      .valid     (out_valid[k]),
      .data      (out[k*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept && (mode == MODE_RR)) begin
      rr_ptr <= (rr_ptr == SEL_W'(N_OUT - 1)) ? '0 : rr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (accept && !in_range && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: per-channel expected-word queues filled
// on accept, drained by a monitor that checks every lane each cycle.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  sel;
  logic        mode;
  logic [31:0] out;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  rr_ptr;
  logic [7:0]  err_cnt;

  logic        in_valid3;
  logic        in_ready3;
  logic [7:0]  in_data3;
  logic [1:0]  sel3;
  logic        mode3;
  logic [23:0] out3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic [1:0]  rr_ptr3;
  logic [1:0]  err_cnt3;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;

  logic [7:0] q[4][$];
  int         mrr = 0;

  always #5 clk = ~clk;

  stream_demux #(.WIDTH(8), .N_OUT(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in(in_data), .sel(sel), .mode(mode), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .rr_ptr(rr_ptr), .err_cnt(err_cnt)
  );

  stream_demux #(.WIDTH(8), .N_OUT(3), .ERR_W(2)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .in(in_data3), .sel(sel3), .mode(mode3), .out(out3), .out_valid(out_valid3),
    .out_ready(out_ready3), .rr_ptr(rr_ptr3), .err_cnt(err_cnt3)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: every held word must be on its lane; empty lanes read zero.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 4; k++) begin
        if (q[k].size() != 0) begin
          check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'd1);
          check($sformatf("lane_data[%0d]", k), 32'(out[k*8 +: 8]), 32'(q[k][0]));
          if (out_ready[k]) void'(q[k].pop_front());
        end else begin
          check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'd0);
          check($sformatf("lane_zero[%0d]", k), 32'(out[k*8 +: 8]), 32'd0);
        end
      end
    end
  end

  // Drive one cycle; after the monitor has retired this cycle's pops, an
  // empty destination queue means the block must accept.
  task automatic step(input bit v, input logic [7:0] d, input logic [1:0] s,
                      input bit m, input logic [3:0] rdy);
    int dsti;
    @(posedge clk); #1;
    in_valid  = v;
    in_data   = d;
    sel       = s;
    mode      = m;
    out_ready = rdy;
    @(negedge clk); #1;
    dsti = m ? mrr : int'(s);
    check("in_ready", 32'(in_ready), 32'(q[dsti].size() == 0));
    check("rr_ptr", 32'(rr_ptr), 32'(mrr));
    check("err_cnt", 32'(err_cnt), 32'd0);
    if (v && q[dsti].size() == 0) begin
      q[dsti].push_back(d);
      if (m) mrr = (mrr + 1) % 4;
    end
  endtask

  initial begin
    int e3;
    rst = 1'b1; in_valid = 0; in_data = 0; sel = 0; mode = 0; out_ready = 4'hF;
    in_valid3 = 0; in_data3 = 0; sel3 = 0; mode3 = 0; out_ready3 = 3'h7;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    started = 1;
    @(negedge clk); #1;
    check("reset_rr_ptr", 32'(rr_ptr), 32'd0);
    check("reset_err_cnt", 32'(err_cnt), 32'd0);

    // Select-routed back-to-back, all sinks ready
    for (int k = 0; k < 4; k++) step(1, 8'hA0 + 8'(k), 2'(k), 0, 4'hF);
    step(0, 8'h00, 0, 0, 4'hF);

    // Backpressure on channel 2, then same-cycle pass-through
    step(1, 8'h11, 2, 0, 4'b1011);
    repeat (3) step(1, 8'h22, 2, 0, 4'b1011);
    step(1, 8'h22, 2, 0, 4'hF);
    step(0, 8'h00, 0, 0, 4'hF);

    // Independence: channel 1 blocked, channel 3 still accepts
    step(1, 8'h05, 1, 0, 4'b0101);
    step(1, 8'h33, 3, 0, 4'b0101);
    @(negedge clk); #2;
    check("indep_out_valid", 32'(out_valid), 32'b1010);
    step(0, 8'h00, 0, 0, 4'hF);
    step(0, 8'h00, 0, 0, 4'hF);

    // Round-robin: six words, then stall on channel 2
    for (int i = 1; i <= 6; i++) step(1, 8'(i), 0, 1, 4'hF);
    step(1, 8'h44, 2, 0, 4'b1011);
    repeat (2) step(1, 8'h08, 0, 1, 4'b1011);
    check("rr_hold", 32'(rr_ptr), 32'd2);
    step(0, 8'h00, 0, 0, 4'hF);
    step(0, 8'h00, 0, 0, 4'hF);

    // Randomised traffic across both modes
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom),
           1'($urandom), 4'($urandom));
    repeat (3) step(0, 8'h00, 0, 0, 4'hF);

    // Reset with two channels full
    step(1, 8'h55, 0, 1, 4'b1100);
    step(1, 8'h66, 1, 1, 4'b1100);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 0;
    @(negedge clk); #1;
    for (int k = 0; k < 4; k++) q[k].delete();
    mrr = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #2;
    check("post_reset_valid", 32'(out_valid), 32'd0);
    check("post_reset_lanes", out, 32'd0);
    check("post_reset_rr", 32'(rr_ptr), 32'd0);
    step(1, 8'h77, 2, 0, 4'hF);
    step(0, 8'h00, 0, 0, 4'hF);

    // Three-channel instance: out-of-range drops and saturation
    e3 = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid3 = 1; in_data3 = 8'(8'hC0 + i); sel3 = 2'd3; mode3 = 0;
      @(negedge clk); #1;
      check("n3_in_ready", 32'(in_ready3), 32'd1);
      check("n3_out_valid", 32'(out_valid3), 32'd0);
      check("n3_err_cnt", 32'(err_cnt3), 32'(e3));
      if (e3 < 3) e3++;
    end
    @(posedge clk); #1;
    in_valid3 = 0;
    @(negedge clk); #1;
    check("n3_err_sat", 32'(err_cnt3), 32'd3);
    check("n3_lanes", 32'(out3), 32'd0);
    // Round-robin wraps after the third channel
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid3 = 1; mode3 = 1; in_data3 = 8'(i + 1);
      @(negedge clk); #1;
      check("n3_rr_ptr", 32'(rr_ptr3), 32'(i % 3));
      check("n3_rr_valid", 32'(out_valid3), (i == 0) ? 32'd0 : 32'(1 << ((i - 1) % 3)));
    end
    @(posedge clk); #1;
    in_valid3 = 0;
    @(negedge clk); #1;
    check("n3_rr_wrapped", 32'(rr_ptr3), 32'd1);
    check("n3_err_hold", 32'(err_cnt3), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
